// File: rtl/half_duplex_spi_pkg.sv
// Shared types and frame-layout constants for the half-duplex SPI register target.
package half_duplex_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_ADDR = 3'd1,
    DATA_WR  = 3'd2,
    DATA_RD  = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int unsigned FRAME_LEN_DEFAULT = 32;

  // Frame bit index of the R/W flag (0 = first bit on the wire) and its read value.
  localparam int unsigned RW_BIT_POS = 0;
  localparam logic        RW_READ    = 1'b1;

  function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/half_duplex_spi_slave_edge_detect.sv
// Synchronizes SCLK/CS_n/SDIO into fabric_clk and decodes CPOL/CPHA into
// sample/shift strobes; all outputs share one pipeline depth so they stay aligned.
module spi_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpol_i,
  input  logic cpha_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic sdio_i,
  output logic sample_edge_o,
  output logic shift_edge_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic sdio_sync_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdio_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s;
  logic cs_s;
  logic lead_c;
  logic trail_c;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
  assign lead_c  = cpol_i ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
  assign trail_c = cpol_i ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      sdio_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      sample_edge_o <= 1'b0;
      shift_edge_o  <= 1'b0;
      cs_fall_o     <= 1'b0;
      cs_rise_o     <= 1'b0;
      sdio_sync_o   <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      sdio_sync_q   <= {sdio_sync_q[SYNC_STAGES-2:0], sdio_i};
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      sample_edge_o <= cpha_i ? trail_c : lead_c;
      shift_edge_o  <= cpha_i ? lead_c : trail_c;
      cs_fall_o     <= cs_prev_q & ~cs_s;
      cs_rise_o     <= ~cs_prev_q & cs_s;
      sdio_sync_o   <= sdio_sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/half_duplex_spi_slave.sv
// 3-wire half-duplex SPI register target: decodes {R/W, addr, data} frames,
// issues register port strobes and returns read data on the shared SDIO line.
module half_duplex_spi_slave
  import half_duplex_spi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  fabric_clk,
  input  logic                  reset,
  input  logic                  spi_cpol,
  input  logic                  spi_cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_sdio_i,
  output logic                  spi_sdio_o,
  output logic                  spi_sdio_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  frame_abort
);

  localparam int unsigned HDR_LEN   = 1 + ADDR_WIDTH;
  localparam int unsigned FRAME_LEN = frame_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned SR_W      = (HDR_LEN > DATA_WIDTH) ? HDR_LEN : DATA_WIDTH;
  localparam int unsigned RW_IDX    = HDR_LEN - 1 - RW_BIT_POS;

  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;
  logic sdio_sync;

  spi_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk_i        (fabric_clk),
    .rst_i        (reset),
    .cpol_i       (spi_cpol),
    .cpha_i       (spi_cpha),
    .sclk_i       (spi_sclk),
    .cs_n_i       (spi_cs_n),
    .sdio_i       (spi_sdio_i),
    .sample_edge_o(sample_edge),
    .shift_edge_o (shift_edge),
    .cs_fall_o    (cs_fall),
    .cs_rise_o    (cs_rise),
    .sdio_sync_o  (sdio_sync)
  );

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [DATA_WIDTH-1:0] rd_sr_q, rd_sr_d;
  logic [1:0]            rd_wait_q, rd_wait_d;
  logic                  rd_done_c;

  always_comb begin
    sr_d      = {sr_q[SR_W-2:0], sdio_sync};
    cnt_d     = cnt_q + CNT_W'(1);
    rd_sr_d   = {rd_sr_q[DATA_WIDTH-2:0], 1'b0};
    rd_wait_d = rd_wait_q - 2'd1;
    rd_done_c = (cnt_q == CNT_W'(FRAME_LEN));
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rd_sr_q     <= '0;
      rd_wait_q   <= '0;
      spi_sdio_o  <= 1'b0;
      spi_sdio_oe <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      frame_abort <= 1'b0;

      // CS_n rising ends any frame; it only counts as an abort before all bits moved.
      if (cs_rise && state_q != IDLE) begin
        state_q     <= IDLE;
        busy        <= 1'b0;
        spi_sdio_oe <= 1'b0;
        frame_abort <= (state_q != DONE) && !(state_q == DATA_RD && rd_done_c);
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q <= CMD_ADDR;
              busy    <= 1'b1;
              cnt_q   <= '0;
              sr_q    <= '0;
            end
          end
          CMD_ADDR: begin
            if (cnt_q == CNT_W'(HDR_LEN)) begin
              reg_addr <= sr_q[ADDR_WIDTH-1:0];
              if (sr_q[RW_IDX] == RW_READ) begin
                reg_rd_en <= 1'b1;
                rd_wait_q <= 2'd2;
                state_q   <= DATA_RD;
              end else begin
                state_q   <= DATA_WR;
              end
            end else if (sample_edge) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
            end
          end
          DATA_WR: begin
            if (rd_done_c) begin
              reg_wr_en   <= 1'b1;
              reg_wr_data <= sr_q[DATA_WIDTH-1:0];
              state_q     <= DONE;
            end else if (sample_edge) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
            end
          end
          DATA_RD: begin
            // Read data is valid the cycle after the strobe is seen by the register port.
            if (rd_wait_q == 2'd1) begin
              rd_sr_q <= reg_rd_data;
            end
            if (rd_wait_q != 2'd0) begin
              rd_wait_q <= rd_wait_d;
            end
            if (shift_edge) begin
              if (rd_done_c) begin
                spi_sdio_oe <= 1'b0;
                state_q     <= DONE;
              end else begin
                spi_sdio_oe <= 1'b1;
                spi_sdio_o  <= rd_sr_q[DATA_WIDTH-1];
                rd_sr_q     <= rd_sr_d;
                cnt_q       <= cnt_d;
              end
            end
          end
          DONE: begin
            spi_sdio_oe <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// Directed bench: a bit-banged SPI master drives frames in several modes and
// checks register-port strobes, returned read data and SDIO enable timing.
module tb_half_duplex_spi_slave;

  localparam int HALF = 8;

  logic        fabric_clk = 1'b0;
  logic        reset;
  logic        spi_cpol, spi_cpha, spi_sclk, spi_cs_n;
  logic        spi_sdio_i, spi_sdio_o, spi_sdio_oe;
  logic [6:0]  reg_addr;
  logic        reg_wr_en, reg_rd_en, busy, frame_abort;
  logic [23:0] reg_wr_data, reg_rd_data;
  logic        m_sdio;

  half_duplex_spi_slave dut (
    .fabric_clk (fabric_clk),
    .reset      (reset),
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_sdio_i (spi_sdio_i),
    .spi_sdio_o (spi_sdio_o),
    .spi_sdio_oe(spi_sdio_oe),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .busy       (busy),
    .frame_abort(frame_abort)
  );

  always #5 fabric_clk = ~fabric_clk;

  // Shared SDIO wire: the slave wins whenever it enables its driver.
  assign spi_sdio_i = spi_sdio_oe ? spi_sdio_o : m_sdio;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, abort_cnt = 0, oe_cyc = 0;
  logic [6:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [23:0] last_wr_data = '0;
  logic [23:0] rd_value = '0;

  always @(negedge fabric_clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      last_rd_addr = reg_addr;
    end
    if (frame_abort) abort_cnt++;
    if (spi_sdio_oe) oe_cyc++;
  end

  // Register port model: data is valid only in the single cycle after the strobe.
  always @(posedge fabric_clk) reg_rd_data <= reg_rd_en ? rd_value : 24'hBAD0BA;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge fabric_clk);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha);
    spi_cpol = cpol;
    spi_cpha = cpha;
    spi_sclk = cpol;
    wait_cyc(4 * HALF);
  endtask

  task automatic xfer(input logic [63:0] tx, input int nbits, input int stop_at,
                      input int rst_at, output logic [63:0] rx);
    logic b;
    rx = '0;
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_at) break;
      if (i == rst_at) begin
        check("oe_before_rst", 64'(spi_sdio_oe), 64'd1);
        reset = 1'b1;
        #1;
        check("oe_at_rst", 64'(spi_sdio_oe), 64'd0);
        check("busy_at_rst", 64'(busy), 64'd0);
        spi_cs_n = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        break;
      end
      b = tx[nbits-1-i];
      if (!spi_cpha) begin
        m_sdio = b;
        wait_cyc(HALF);
        spi_sclk = ~spi_cpol;
        rx = {rx[62:0], spi_sdio_i};
        wait_cyc(HALF);
        spi_sclk = spi_cpol;
      end else begin
        spi_sclk = ~spi_cpol;
        m_sdio = b;
        wait_cyc(HALF);
        spi_sclk = spi_cpol;
        rx = {rx[62:0], spi_sdio_i};
        wait_cyc(HALF);
      end
    end
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    logic [63:0] rx;
    int w0, r0, a0, o0;

    reset = 1'b1;
    spi_cs_n = 1'b1;
    spi_cpol = 1'b0;
    spi_cpha = 1'b0;
    spi_sclk = 1'b0;
    m_sdio = 1'b0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(10);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_oe", 64'(spi_sdio_oe), 64'd0);
    check("rst_sdio_o", 64'(spi_sdio_o), 64'd0);
    check("rst_addr", 64'(reg_addr), 64'd0);
    check("rst_wr_data", 64'(reg_wr_data), 64'd0);
    check("rst_strobes", 64'({reg_wr_en, reg_rd_en, frame_abort}), 64'd0);

    // Mode 0 write
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc;
    xfer(64'({1'b0, 7'h15, 24'hA5C3F0}), 32, -1, -1, rx);
    check("m0w_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("m0w_addr", 64'(last_wr_addr), 64'h15);
    check("m0w_data", 64'(last_wr_data), 64'hA5C3F0);
    check("m0w_oe_cyc", 64'(oe_cyc - o0), 64'd0);
    check("m0w_rd_cnt", 64'(rd_cnt - r0), 64'd0);
    check("m0w_busy", 64'(busy), 64'd0);

    // Mode 0 read: SDIO driven from shift edge 8 through release on shift edge 32
    rd_value = 24'h123456;
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc;
    xfer(64'({1'b1, 7'h7F, 24'h0}), 32, -1, -1, rx);
    check("m0r_rd_cnt", 64'(rd_cnt - r0), 64'd1);
    check("m0r_addr", 64'(last_rd_addr), 64'h7F);
    check("m0r_data", 64'(rx[23:0]), 64'h123456);
    check("m0r_oe_cyc", 64'(oe_cyc - o0), 64'(24 * 2 * HALF));
    check("m0r_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // Mode 3 read then write with a 2-SCLK CS gap
    set_mode(1'b1, 1'b1);
    rd_value = 24'hFFFF00;
    r0 = rd_cnt; a0 = abort_cnt; o0 = oe_cyc;
    xfer(64'({1'b1, 7'h2A, 24'h0}), 32, -1, -1, rx);
    check("m3r_data", 64'(rx[23:0]), 64'hFFFF00);
    check("m3r_addr", 64'(last_rd_addr), 64'h2A);
    check("m3r_rd_cnt", 64'(rd_cnt - r0), 64'd1);
    check("m3r_oe_cyc", 64'(oe_cyc - o0), 64'(24 * 2 * HALF + HALF));
    check("m3r_no_abort", 64'(abort_cnt - a0), 64'd0);
    check("m3_gap_busy", 64'(busy), 64'd0);
    check("m3_gap_oe", 64'(spi_sdio_oe), 64'd0);
    wait_cyc(3 * HALF);
    w0 = wr_cnt;
    xfer(64'({1'b0, 7'h01, 24'h000001}), 32, -1, -1, rx);
    check("m3w_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("m3w_addr", 64'(last_wr_addr), 64'h01);
    check("m3w_data", 64'(last_wr_data), 64'h000001);

    // Abort after 20 bits of a write, then a clean frame
    set_mode(1'b0, 1'b0);
    w0 = wr_cnt; a0 = abort_cnt;
    xfer(64'({1'b0, 7'h55, 24'h123456}), 32, 20, -1, rx);
    check("abort_pulse", 64'(abort_cnt - a0), 64'd1);
    check("abort_no_wr", 64'(wr_cnt - w0), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    xfer(64'({1'b0, 7'h33, 24'h0F0F0F}), 32, -1, -1, rx);
    check("post_abort_wr", 64'(wr_cnt - w0), 64'd1);
    check("post_abort_addr", 64'(last_wr_addr), 64'h33);
    check("post_abort_data", 64'(last_wr_data), 64'h0F0F0F);
    check("post_abort_cnt", 64'(abort_cnt - a0), 64'd1);

    // Reset during read bit 12, then a normal read
    rd_value = 24'hABCDEF;
    xfer(64'({1'b1, 7'h10, 24'h0}), 32, -1, 12, rx);
    check("post_rst_addr", 64'(reg_addr), 64'd0);
    check("post_rst_wr_data", 64'(reg_wr_data), 64'd0);
    check("post_rst_oe", 64'(spi_sdio_oe), 64'd0);
    check("post_rst_sdio_o", 64'(spi_sdio_o), 64'd0);
    rd_value = 24'hC0FFEE;
    xfer(64'({1'b1, 7'h44, 24'h0}), 32, -1, -1, rx);
    check("post_rst_rd_data", 64'(rx[23:0]), 64'hC0FFEE);
    check("post_rst_rd_addr", 64'(last_rd_addr), 64'h44);

    // 36 SCLKs in one CS window: trailing bits land in DONE and are ignored
    w0 = wr_cnt; a0 = abort_cnt;
    xfer({28'h0, 1'b0, 7'h0A, 24'h5AA55A, 4'hF}, 36, -1, -1, rx);
    check("ovr_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    check("ovr_addr", 64'(last_wr_addr), 64'h0A);
    check("ovr_data", 64'(last_wr_data), 64'h5AA55A);
    check("ovr_no_abort", 64'(abort_cnt - a0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
